// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, default widths and the ALU op enum
package fetch_unit_pkg;

   localparam int         DEF_PC_W       = 10;
   localparam int         DEF_INSTR_W    = 9;
   localparam logic [8:0] DEF_HALT_INSTR = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fetch_state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_JMP
   } alu_op_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// rtl/fetch_unit_pc_next.sv - combinational next fetch address: start, branch, increment or hold
module pc_next
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = DEF_PC_W
) (
   input  logic            start,
   input  logic [PC_W-1:0] start_addr,
   input  logic            branch,
   input  logic [PC_W-1:0] base_pc,
   input  logic [7:0]      offset,
   input  logic            advance,
   input  logic [PC_W-1:0] cur_pc,
   output logic [PC_W-1:0] next_pc
);

   localparam logic [PC_W-1:0] ONE = PC_W'(1);

   logic [PC_W-1:0] offset_ext;

   // Branch targets are relative to the branching instruction; the add wraps mod 2^PC_W.
   assign offset_ext = {{(PC_W-8){offset[7]}}, offset};

   always_comb begin
      next_pc = cur_pc;
      if (start) begin
         next_pc = start_addr;
      end else if (branch) begin
         next_pc = base_pc + offset_ext;
      end else if (advance) begin
         next_pc = cur_pc + ONE;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch / PC stage with branch redirect, halt, stall and run counter
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 PC_W       = DEF_PC_W,
   parameter int                 INSTR_W    = DEF_INSTR_W,
   parameter logic [INSTR_W-1:0] HALT_INSTR = DEF_HALT_INSTR
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [PC_W-1:0]    start_addr,
   input  logic               stall,
   input  logic               jump_flag,
   input  logic [7:0]         jump_offset,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               done,
   output logic [15:0]        cycle_count
);

   fetch_state_t    state_q, state_d;
   logic            fire, halt_hit, branch_hit, advance;
   logic [PC_W-1:0] addr_d, pc_d;
   logic            valid_d;
   logic [15:0]     count_d;

   // A fetch cycle happens only in RUN without stall; branch and halt are sampled only then.
   assign fire       = (state_q == RUN) && !stall;
   assign halt_hit   = fire && instr_valid && (imem_rdata == HALT_INSTR);
   assign branch_hit = fire && instr_valid && jump_flag && !halt_hit;
   assign advance    = fire && !halt_hit;

   assign imem_en = fire;
   assign done    = (state_q == DONE);
   assign instr   = imem_rdata;

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .start      (start),
      .start_addr (start_addr),
      .branch     (branch_hit),
      .base_pc    (instr_pc),
      .offset     (jump_offset),
      .advance    (advance),
      .cur_pc     (imem_addr),
      .next_pc    (addr_d)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = instr_pc;
      valid_d = instr_valid;
      count_d = cycle_count;
      if (start) begin
         state_d = RUN;
         valid_d = 1'b0;
         count_d = 16'd0;
      end else begin
         if ((state_q == RUN) && (cycle_count != 16'hFFFF)) begin
            count_d = cycle_count + 16'd1;
         end
         if (halt_hit) begin
            state_d = DONE;
            valid_d = 1'b0;
         end else if (fire) begin
            pc_d    = imem_addr;
            // The sequential fetch in flight behind a taken branch is squashed.
            valid_d = !branch_hit;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         imem_addr   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         cycle_count <= 16'd0;
      end else begin
         state_q     <= state_d;
         imem_addr   <= addr_d;
         instr_pc    <= pc_d;
         instr_valid <= valid_d;
         cycle_count <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a ROM and a pipeline reference model
module tb_fetch_unit;

   localparam logic [8:0] HALT = 9'h1FF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  start_addr = '0;
   logic        stall = 1'b0;
   logic        jump_flag = 1'b0;
   logic [7:0]  jump_offset = '0;
   logic [9:0]  imem_addr, instr_pc;
   logic        imem_en, instr_valid, done;
   logic [8:0]  imem_rdata = '0;
   logic [8:0]  instr;
   logic [15:0] cycle_count;

   logic [8:0]  rom [1024];
   int          checks = 0;
   int          errors = 0;

   // Reference model: mode 0 idle / 1 run / 2 done; fetch slot m_fa, presented slot m_pc/m_v.
   int          m_mode;
   logic [9:0]  m_fa, m_pc;
   logic        m_v;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .start_addr  (start_addr),
      .stall       (stall),
      .jump_flag   (jump_flag),
      .jump_offset (jump_offset),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .done        (done),
      .cycle_count (cycle_count)
   );

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= rom[imem_addr];
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode <= 0; m_fa <= '0; m_pc <= '0; m_v <= 1'b0; m_cnt <= '0;
      end else if (start) begin
         m_mode <= 1; m_fa <= start_addr; m_v <= 1'b0; m_cnt <= '0;
      end else if (m_mode == 1) begin
         if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
         if (!stall) begin
            if (m_v && rom[m_pc] == HALT) begin
               m_mode <= 2; m_v <= 1'b0;
            end else begin
               m_v  <= !(m_v && jump_flag);
               m_pc <= m_fa;
               m_fa <= (m_v && jump_flag)
                       ? 10'((int'(m_pc) + int'($signed(jump_offset)) + 1024) % 1024)
                       : 10'((int'(m_fa) + 1) % 1024);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_rom(input int halt_pct);
      for (int i = 0; i < 1024; i++)
         rom[i] = ($urandom_range(0, 99) < halt_pct) ? HALT : 9'($urandom_range(0, 510));
   endtask

   task automatic do_start(input logic [9:0] a);
      start = 1'b1; start_addr = a;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got %0d exp 0", imem_addr); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got %0b exp 0", imem_en); end
      checks++; if (instr_pc !== 10'd0) begin errors++; $display("FAIL reset_instr_pc got %0d exp 0", instr_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0b exp 0", instr_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
      checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cycle_count got %0d exp 0", cycle_count); end
      reset_n = 1'b1;
      repeat (2) step();
      checks++; if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL idle_no_start got v=%0b en=%0b exp 0 0", instr_valid, imem_en); end
   endtask

   task automatic test_sequential();
      fill_rom(0);
      do_start(10'd5);
      checks++; if (imem_addr !== 10'd5 || imem_en !== 1'b1) begin errors++; $display("FAIL start_fetch got addr=%0d en=%0b exp 5 1", imem_addr, imem_en); end
      checks++; if (instr_valid !== 1'b0 || cycle_count !== 16'd0) begin errors++; $display("FAIL start_latency got v=%0b cnt=%0d exp 0 0", instr_valid, cycle_count); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'(5 + i)) begin errors++; $display("FAIL seq_pc got v=%0b pc=%0d exp 1 %0d", instr_valid, instr_pc, 5 + i); end
         checks++; if (instr !== rom[5 + i]) begin errors++; $display("FAIL seq_instr got %0h exp %0h", instr, rom[5 + i]); end
         checks++; if (cycle_count !== 16'(i + 1)) begin errors++; $display("FAIL seq_count got %0d exp %0d", cycle_count, i + 1); end
      end
   endtask

   task automatic branch_at(input logic [9:0] at, input logic [7:0] off, input logic [9:0] target);
      for (int k = 0; k < 40 && !(instr_valid && instr_pc == at); k++) step();
      checks++; if (!(instr_valid === 1'b1 && instr_pc === at)) begin errors++; $display("FAIL branch_reach got pc=%0d exp %0d", instr_pc, at); end
      jump_flag = 1'b1; jump_offset = off;
      step();
      jump_flag = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble got v=%0b exp 0", instr_valid); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== target) begin errors++; $display("FAIL branch_target got v=%0b pc=%0d exp 1 %0d", instr_valid, instr_pc, target); end
      checks++; if (instr !== rom[target]) begin errors++; $display("FAIL branch_instr got %0h exp %0h", instr, rom[target]); end
   endtask

   task automatic test_branch();
      fill_rom(0);
      do_start(10'd8);
      branch_at(10'd10, 8'hFC, 10'd6);
      branch_at(10'd10, 8'h05, 10'd15);
   endtask

   task automatic test_stall();
      logic [15:0] c0;
      fill_rom(0);
      do_start(10'd18);
      for (int k = 0; k < 10 && !(instr_valid && instr_pc == 10'd20); k++) step();
      c0 = cycle_count;
      stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         jump_flag = (s == 1); jump_offset = 8'h10;
         step();
         checks++; if (imem_en !== 1'b0 || imem_addr !== 10'd21) begin errors++; $display("FAIL stall_fetch got en=%0b addr=%0d exp 0 21", imem_en, imem_addr); end
         checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd20 || instr !== rom[20]) begin errors++; $display("FAIL stall_hold got v=%0b pc=%0d i=%0h exp 1 20 %0h", instr_valid, instr_pc, instr, rom[20]); end
         checks++; if (cycle_count !== c0 + 16'(s + 1)) begin errors++; $display("FAIL stall_count got %0d exp %0d", cycle_count, c0 + 16'(s + 1)); end
      end
      stall = 1'b0; jump_flag = 1'b0;
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd21) begin errors++; $display("FAIL stall_release got v=%0b pc=%0d exp 1 21", instr_valid, instr_pc); end
   endtask

   task automatic test_halt();
      logic [15:0] c0;
      fill_rom(0);
      rom[30] = HALT;
      do_start(10'd28);
      for (int k = 0; k < 10 && !(instr_valid && instr_pc == 10'd30); k++) step();
      checks++; if (instr !== HALT) begin errors++; $display("FAIL halt_present got %0h exp %0h", instr, HALT); end
      jump_flag = 1'b1; jump_offset = 8'($urandom);
      step();
      jump_flag = 1'b0;
      c0 = cycle_count;
      checks++; if (done !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL halt_done got d=%0b v=%0b en=%0b exp 1 0 0", done, instr_valid, imem_en); end
      repeat (3) step();
      checks++; if (cycle_count !== c0 || done !== 1'b1) begin errors++; $display("FAIL halt_frozen got cnt=%0d d=%0b exp %0d 1", cycle_count, done, c0); end
      do_start(10'd0);
      checks++; if (done !== 1'b0 || cycle_count !== 16'd0 || imem_addr !== 10'd0) begin errors++; $display("FAIL restart got d=%0b cnt=%0d addr=%0d exp 0 0 0", done, cycle_count, imem_addr); end
   endtask

   task automatic test_wrap();
      fill_rom(0);
      do_start(10'd1023);
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd1023) begin errors++; $display("FAIL wrap_top got v=%0b pc=%0d exp 1 1023", instr_valid, instr_pc); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd0) begin errors++; $display("FAIL wrap_zero got v=%0b pc=%0d exp 1 0", instr_valid, instr_pc); end
      branch_at(10'd2, 8'h80, 10'd898);
   endtask

   task automatic test_reset_midrun();
      fill_rom(0);
      do_start(10'd100);
      repeat (3) step();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL midrun_pre got v=%0b exp 1", instr_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (imem_addr !== 10'd0 || imem_en !== 1'b0 || instr_pc !== 10'd0) begin errors++; $display("FAIL midrun_async got addr=%0d en=%0b pc=%0d exp 0 0 0", imem_addr, imem_en, instr_pc); end
      checks++; if (instr_valid !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin errors++; $display("FAIL midrun_async2 got v=%0b d=%0b cnt=%0d exp 0 0 0", instr_valid, done, cycle_count); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (instr_valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 10'd0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle got v=%0b en=%0b addr=%0d d=%0b exp 0 0 0 0", instr_valid, imem_en, imem_addr, done); end
      end
   endtask

   task automatic test_random();
      fill_rom(3);
      for (int c = 0; c < 400; c++) begin
         start       = (c == 0) || ($urandom_range(0, 99) < 4);
         start_addr  = 10'($urandom);
         stall       = ($urandom_range(0, 99) < 25);
         jump_flag   = instr_valid && ($urandom_range(0, 99) < 25);
         jump_offset = 8'($urandom);
         step();
         checks++; if (instr_valid !== m_v || done !== (m_mode == 2)) begin errors++; $display("FAIL rnd_flags c=%0d got v=%0b d=%0b exp %0b %0b", c, instr_valid, done, m_v, m_mode == 2); end
         checks++; if (cycle_count !== m_cnt) begin errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, cycle_count, m_cnt); end
         checks++; if (imem_en !== (m_mode == 1 && !stall)) begin errors++; $display("FAIL rnd_en c=%0d got %0b exp %0b", c, imem_en, m_mode == 1 && !stall); end
         if (m_mode == 1) begin
            checks++; if (imem_addr !== m_fa) begin errors++; $display("FAIL rnd_addr c=%0d got %0d exp %0d", c, imem_addr, m_fa); end
         end
         if (m_v) begin
            checks++; if (instr_pc !== m_pc || instr !== rom[m_pc]) begin errors++; $display("FAIL rnd_instr c=%0d got pc=%0d i=%0h exp %0d %0h", c, instr_pc, instr, m_pc, rom[m_pc]); end
         end
      end
      start = 1'b0; stall = 1'b0; jump_flag = 1'b0;
   endtask

   task automatic test_saturate();
      stall = 1'b1;
      do_start(10'd7);
      repeat (65540) step();
      checks++; if (cycle_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %0h exp ffff", cycle_count); end
      step();
      checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h exp ffff", cycle_count); end
      stall = 1'b0;
   endtask

   initial begin
      fill_rom(0);
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_halt();
      test_wrap();
      test_reset_midrun();
      test_random();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
